fetch_prefetch_queue: RTL

// - Instruction prefetch stage between the program counter and decode.
// - Generates sequential fetch addresses and issues them to instruction memory over a req/gnt + rvalid bus.
// - Buffers returned instructions, with their PCs, in a DEPTH-entry FIFO.
// - Presents instructions to decode over a valid/ready handshake.
// - A branch/jump redirect flushes the queue and restarts fetching at the target.

---
 rtl/fetch_prefetch_queue.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch over req/gnt+rvalid, DEPTH-entry PC/instr FIFO to decode.
// Optional FETCH_BYPASS_EN: zero-latency path from imem response to decode when the FIFO is empty.
module fetch_prefetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    redirect_i,
   input  logic [31:0]             redirect_pc_i,
   output logic                    imem_req_o,
   output logic [31:0]             imem_addr_o,
   input  logic                    imem_gnt_i,
   input  logic                    imem_rvalid_i,
   input  logic [31:0]             imem_rdata_i,
   output logic                    out_valid_o,
   output logic [31:0]             out_pc_o,
   output logic [31:0]             out_instr_o,
   input  logic                    out_ready_i,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(DEPTH);

   typedef enum logic {
      S_FETCH,
      S_DRAIN
   } state_e;

   state_e          state_q, state_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [31:0]     push_pc_q, push_pc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   discard_q, discard_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [31:0]     pc_mem_q    [DEPTH];
   logic [31:0]     instr_mem_q [DEPTH];

   logic            credit_ok;
   logic            req;
   logic            grant;
   logic            fifo_valid;
   logic            bypass;
   logic            pop;
   logic            accept;
   logic            push;
   logic [31:0]     target_pc;
   logic [CW-1:0]   pending;

   // Every in-flight request owns a FIFO slot, so pushes can never overflow.
   assign credit_ok  = ({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_EXT;
   assign req        = rst && (state_q == S_FETCH) && !redirect_i && credit_ok;
   assign grant      = req && imem_gnt_i;
   assign fifo_valid = (count_q != '0) && !redirect_i;
   assign pop        = fifo_valid && out_ready_i;
   assign accept     = (state_q == S_FETCH) && imem_rvalid_i && !redirect_i;
   assign target_pc  = redirect_pc_i & 32'hFFFF_FFFC;
   assign pending    = discard_q + outstanding_q;

`ifdef FETCH_BYPASS_EN
   assign bypass      = (state_q == S_FETCH) && (count_q == '0) && imem_rvalid_i && !redirect_i;
   assign out_valid_o = fifo_valid || bypass;
   assign out_pc_o    = bypass ? push_pc_q    : pc_mem_q[rd_ptr_q];
   assign out_instr_o = bypass ? imem_rdata_i : instr_mem_q[rd_ptr_q];
`else
   assign bypass      = 1'b0;
   assign out_valid_o = fifo_valid;
   assign out_pc_o    = pc_mem_q[rd_ptr_q];
   assign out_instr_o = instr_mem_q[rd_ptr_q];
`endif

   // A bypassed response taken by decode is consumed without ever entering the FIFO.
   assign push = accept && !(bypass && out_ready_i);

   assign imem_req_o  = req;
   assign imem_addr_o = fetch_pc_q;
   assign count_o     = count_q;

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      push_pc_d     = push_pc_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      count_d       = count_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;

      if (redirect_i) begin
         fetch_pc_d    = target_pc;
         push_pc_d     = target_pc;
         outstanding_d = '0;
         count_d       = '0;
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         discard_d     = (imem_rvalid_i && (pending != '0)) ? pending - CW'(1) : pending;
         state_d       = (discard_d != '0) ? S_DRAIN : S_FETCH;
      end else if (state_q == S_DRAIN) begin
         if (imem_rvalid_i && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
         end
         if (discard_d == '0) begin
            state_d = S_FETCH;
         end
      end else begin
         if (grant) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (accept) begin
            push_pc_d = push_pc_q + 32'd4;
         end
         outstanding_d = outstanding_q + CW'(grant) - CW'(accept);
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_FETCH;
         fetch_pc_q    <= RESET_PC;
         push_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         push_pc_q     <= push_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         count_q       <= count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         if (push) begin
            pc_mem_q[wr_ptr_q]    <= push_pc_q;
            instr_mem_q[wr_ptr_q] <= imem_rdata_i;
         end
      end
   end

endmodule
